// File: rtl/contador_pkg.sv
// Shared types and defaults for the 4-bit counter command sequencer.
// Command opcodes match the CmdOp encoding on the sequencer port.
package contador_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_GOTO = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/seq_step_counter.sv
// Loadable down-counter holding the remaining step count of an UP/DOWN command.
// Flags tell the sequencer when no steps remain and when the current step is the last one.
module seq_step_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             last
);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/contador_sequencer.sv
// Command-driven controller for the external up/down counter with load.
// Accepts LOAD / UP N / DOWN N / GOTO commands and reports Busy, Done, Wrapped and Aborted.
module contador_sequencer
    import contador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdOp,
    input  logic [WIDTH-1:0] CmdArg,
    input  logic             Abort,
    output logic             CntLoad,
    output logic             CntUpDown,
    output logic             CntEnable,
    output logic [WIDTH-1:0] CntEntrada,
    input  logic [WIDTH-1:0] CntSaida,
    output logic             Busy,
    output logic             Done,
    output logic             Wrapped,
    output logic             Aborted
);

    state_e            state_q;
    state_e            state_d;
    cmd_op_e           op_q;
    cmd_op_e           cmd_op;
    logic [WIDTH-1:0]  arg_q;
    logic              up_q;
    logic              cmd_up;
    logic              wrapped_q;
    logic              aborted_q;

    logic              accept;
    logic              abort_hit;
    logic              wrap_hit;
    logic              step_dec;
    logic              step_zero;
    logic              step_last;
    logic [WIDTH-1:0]  step_count;
    logic [WIDTH-1:0]  saida_next;

    assign cmd_op = cmd_op_e'(CmdOp);

    // GOTO direction is frozen at acceptance; equal values never enter RUN.
    assign cmd_up = (cmd_op == OP_UP) || ((cmd_op == OP_GOTO) && (CmdArg > CntSaida));

    // Value the counter will show after the current enabled step.
    assign saida_next = up_q ? (CntSaida + WIDTH'(1)) : (CntSaida - WIDTH'(1));

    seq_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (accept),
        .load_value (CmdArg),
        .dec        (step_dec),
        .count      (step_count),
        .zero       (step_zero),
        .last       (step_last)
    );

    always_comb begin
        // NOTE: every output and next-state term gets a default first so no path infers a latch.
        state_d    = state_q;
        accept     = 1'b0;
        abort_hit  = 1'b0;
        wrap_hit   = 1'b0;
        step_dec   = 1'b0;
        CmdReady   = 1'b0;
        CntLoad    = 1'b0;
        CntUpDown  = 1'b0;
        CntEnable  = 1'b0;
        CntEntrada = '0;
        Busy       = 1'b0;
        Done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) begin
                    accept = 1'b1;
                    unique case (cmd_op)
                        OP_LOAD:        state_d = S_LOAD;
                        OP_UP, OP_DOWN: state_d = (CmdArg == '0) ? S_DONE : S_RUN;
                        OP_GOTO:        state_d = (CmdArg == CntSaida) ? S_DONE : S_RUN;
                        default:        state_d = S_IDLE;
                    endcase
                end
            end

            S_LOAD: begin
                Busy       = 1'b1;
                CntLoad    = 1'b1;
                CntEntrada = arg_q;
                abort_hit  = Abort;
                state_d    = S_DONE;
            end

            S_RUN: begin
                Busy      = 1'b1;
                CntUpDown = up_q;
                abort_hit = Abort;
                if (op_q == OP_GOTO) begin
                    CntEnable = (CntSaida != arg_q);
                    // Exit on the step that lands on the target, so DONE already shows it.
                    if (!CntEnable || (saida_next == arg_q)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    CntEnable = !step_zero;
                    step_dec  = CntEnable;
                    if (step_last || step_zero) begin
                        state_d = S_DONE;
                    end
                end
                if (Abort) begin
                    state_d = S_DONE;
                end
                wrap_hit = CntEnable && (up_q ? (CntSaida == '1) : (CntSaida == '0));
            end

            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            arg_q     <= '0;
            up_q      <= 1'b0;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= cmd_op;
                arg_q     <= CmdArg;
                up_q      <= cmd_up;
                wrapped_q <= 1'b0;
                aborted_q <= 1'b0;
            end else begin
                if (wrap_hit) begin
                    wrapped_q <= 1'b1;
                end
                if (abort_hit) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    assign Wrapped = wrapped_q;
    assign Aborted = aborted_q;

endmodule

// File: tb/tb_contador_sequencer.sv
// Scoreboard bench for contador_sequencer driving a behavioural 4-bit up/down counter.
// Expected results come from an arithmetic model of each command; a monitor checks them on Done.
module tb_contador_sequencer;
    import contador_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         cnt_rst_n = 1'b0;
    logic         CmdValid = 1'b0;
    logic         CmdReady;
    logic [1:0]   CmdOp = 2'b00;
    logic [W-1:0] CmdArg = '0;
    logic         Abort = 1'b0;
    logic         CntLoad;
    logic         CntUpDown;
    logic         CntEnable;
    logic [W-1:0] CntEntrada;
    logic [W-1:0] saida;
    logic         Busy;
    logic         Done;
    logic         Wrapped;
    logic         Aborted;

    always #5 Clock = ~Clock;

    contador_sequencer #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .CmdValid   (CmdValid),
        .CmdReady   (CmdReady),
        .CmdOp      (CmdOp),
        .CmdArg     (CmdArg),
        .Abort      (Abort),
        .CntLoad    (CntLoad),
        .CntUpDown  (CntUpDown),
        .CntEnable  (CntEnable),
        .CntEntrada (CntEntrada),
        .CntSaida   (saida),
        .Busy       (Busy),
        .Done       (Done),
        .Wrapped    (Wrapped),
        .Aborted    (Aborted)
    );

    // Stand-in for the existing counter, enable-gated by CntEnable.
    always_ff @(posedge Clock or negedge cnt_rst_n) begin
        if (!cnt_rst_n)      saida <= '0;
        else if (CntLoad)    saida <= CntEntrada;
        else if (CntEnable)  saida <= CntUpDown ? saida + 4'd1 : saida - 4'd1;
    end

    typedef struct {
        string name;
        int    lat;
        int    saida;
        int    wrapped;
        int    aborted;
        int    enables;
        int    loads;
        bit    up;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   model_cnt = 0;
    bit   stop_run = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        else
            passed++;
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic int outs();
        return int'({CmdReady, CntLoad, CntUpDown, CntEnable, CntEntrada, Busy, Done, Wrapped, Aborted});
    endfunction

    function automatic int busy_len(input cmd_op_e op, input int arg, input int s);
        case (op)
            OP_LOAD:        return 1;
            OP_UP, OP_DOWN: return arg;
            default:        return (arg > s) ? arg - s : s - arg;
        endcase
    endfunction

    // Result of one command from the counter start value s; k>0 aborts in busy cycle k.
    function automatic exp_t predict(input cmd_op_e op, input int arg, input int k, input int s);
        exp_t e;
        int   steps;
        e.name    = op.name();
        e.aborted = (k > 0) ? 1 : 0;
        e.wrapped = 0;
        e.loads   = 0;
        e.enables = 0;
        e.up      = 0;
        if (op == OP_LOAD) begin
            e.loads = 1;
            e.saida = arg;
            e.lat   = 2;
        end else begin
            e.up    = (op == OP_UP) || ((op == OP_GOTO) && (arg > s));
            steps   = (k > 0) ? k : busy_len(op, arg, s);
            e.enables = steps;
            e.lat     = steps + 1;
            if (e.up) begin
                e.saida = (s + steps) % 16;
                e.wrapped = (op != OP_GOTO && s + steps > 15) ? 1 : 0;
            end else begin
                e.saida = (s - steps + 16) % 16;
                e.wrapped = (op != OP_GOTO && steps > s) ? 1 : 0;
            end
        end
        return e;
    endfunction

    // Monitor: follows each accepted command and compares against the queue head on Done.
    int cyc = 0;
    int en  = 0;
    int ld  = 0;
    bit inflight = 0;
    bit ud_bad = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                inflight = 0;
            end else begin
                if (CntLoad || CntEnable) check("load_enable_exclusive", int'(CntLoad & CntEnable), 0);
                if (!CntLoad && CntEntrada != '0) check("entrada_quiet", int'(CntEntrada), 0);
                if (inflight) begin
                    cyc++;
                    if (CntEnable) begin
                        en++;
                        if (exp_q.size() > 0 && CntUpDown != exp_q[0].up) ud_bad = 1;
                    end
                    if (CntLoad) ld++;
                    if (Done) begin
                        if (exp_q.size() == 0) begin
                            fail("unexpected_done_no_expectation");
                        end else begin
                            e = exp_q.pop_front();
                            check({e.name, "_latency"}, cyc, e.lat);
                            check({e.name, "_saida"}, int'(saida), e.saida);
                            check({e.name, "_wrapped"}, int'(Wrapped), e.wrapped);
                            check({e.name, "_aborted"}, int'(Aborted), e.aborted);
                            check({e.name, "_enables"}, en, e.enables);
                            check({e.name, "_loads"}, ld, e.loads);
                            if (e.enables > 0) check({e.name, "_updown"}, int'(ud_bad), 0);
                            check({e.name, "_busy_in_done"}, int'(Busy), 0);
                        end
                        inflight = 0;
                    end
                end else if (Done) begin
                    fail("unexpected_done");
                end
                if (CmdValid && CmdReady) begin
                    inflight = 1;
                    cyc = 0;
                    en = 0;
                    ld = 0;
                    ud_bad = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge Clock);
        end
        fail("idle_timeout");
        stop_run = 1;
    endtask

    task automatic issue(input cmd_op_e op, input int arg, input int k);
        exp_t e;
        if (stop_run) return;
        e = predict(op, arg, k, model_cnt);
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdArg   = 4'(arg);
        @(posedge Clock);
        #1;
        CmdValid = 1'b0;
        CmdOp    = 2'(($urandom_range(0, 3)));
        CmdArg   = 4'($urandom_range(0, 15));
        if (k > 0) begin
            repeat (k - 1) @(posedge Clock);
            #1 Abort = 1'b1;
            @(posedge Clock);
            #1 Abort = 1'b0;
        end
        wait_idle();
        model_cnt = e.saida;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_op_e op;
        int      arg;
        int      k;
        int      busy;
        bit      done_seen;

        #8;
        check("reset_outputs", outs(), 12'h800);
        #4;
        Reset = 1'b1;
        cnt_rst_n = 1'b1;

        // Directed cases
        issue(OP_LOAD, 4'h3, 0);
        issue(OP_LOAD, 4'hA, 0);
        issue(OP_LOAD, 4'hE, 0);
        issue(OP_UP,   5,    0);
        issue(OP_DOWN, 0,    0);
        issue(OP_LOAD, 4'h9, 0);
        issue(OP_GOTO, 4'h2, 0);
        issue(OP_LOAD, 4'h9, 0);
        issue(OP_GOTO, 4'h9, 0);
        issue(OP_LOAD, 4'h0, 0);
        issue(OP_UP,   10,   3);
        issue(OP_DOWN, 3,    0);
        issue(OP_LOAD, 4'h0, 1);

        // Reset pulsed during an UP 8 run
        if (!stop_run) begin
            @(posedge Clock);
            #1;
            CmdValid = 1'b1;
            CmdOp    = OP_UP;
            CmdArg   = 4'd8;
            @(posedge Clock);
            #1 CmdValid = 1'b0;
            repeat (3) @(posedge Clock);
            #2 Reset = 1'b0;
            #1 check("reset_mid_run_outputs", outs(), 12'h800);
            @(negedge Clock);
            @(posedge Clock);
            #3 Reset = 1'b1;
            model_cnt = (model_cnt + 3) % 16;
            done_seen = 0;
            repeat (4) begin
                @(negedge Clock);
                if (Done) done_seen = 1;
            end
            check("no_done_after_reset", int'(done_seen), 0);
            check("saida_after_reset", int'(saida), model_cnt);
            issue(OP_LOAD, 5, 0);
        end

        // Randomized commands
        for (int n = 0; n < 150 && !stop_run; n++) begin
            op  = cmd_op_e'($urandom_range(0, 3));
            arg = $urandom_range(0, 15);
            if (op == OP_GOTO && $urandom_range(0, 7) == 0) arg = model_cnt;
            if ((op == OP_UP || op == OP_DOWN) && $urandom_range(0, 9) == 0) arg = 0;
            busy = busy_len(op, arg, model_cnt);
            k = 0;
            if (busy > 0 && $urandom_range(0, 3) == 0) k = $urandom_range(1, busy);
            issue(op, arg, k);
        end

        repeat (2) @(negedge Clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
